register_tree_feeder: RTL and testbench

Stream front-end for `register_tree`. It accepts keys on a valid/ready input stream and drives the tree's `i_replace`/`i_data` pins. For each accepted key it captures the evicted top item from the tree's `o_data` and returns it on a valid/ready output stream. It enforces the settle interval the tree needs between replace operations, so upstream logic never has to track tree timing.

---
 rtl/register_tree_feeder.sv | 145 ++++++++++++++
 tb/tb_register_tree_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_tree_feeder.sv
// register_tree_feeder
//
// Stream front-end for a register_tree priority queue. Keys arrive on a
// valid/ready input stream. For every accepted key the feeder captures the
// current tree top (the item about to be evicted), issues a single-cycle
// replace pulse carrying the new key, and then waits out the tree's settle
// interval before accepting another key. The captured item is returned on a
// one-entry valid/ready output stream.
//
// Ports:
//   CLK            clock, all state on the rising edge
//   RST            asynchronous active-high reset
//   i_in_valid     input key valid
//   o_in_ready     feeder can accept a key (combinational)
//   i_in_data      input key
//   o_out_valid    evicted key valid
//   i_out_ready    downstream accepts the evicted key
//   o_out_data     evicted key
//   o_replace      to tree i_replace, single-cycle pulse
//   o_replace_data to tree i_data, holds the last accepted key
//   i_top_data     from tree o_data (current maximum)
//   o_busy         high while a replace/settle sequence is in progress
//   o_evict_count  number of completed output handshakes (wraps)
module register_tree_feeder #(
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 3,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [DATA_WIDTH-1:0]  i_in_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [DATA_WIDTH-1:0]  o_out_data,
    output logic                   o_replace,
    output logic [DATA_WIDTH-1:0]  o_replace_data,
    input  logic [DATA_WIDTH-1:0]  i_top_data,
    output logic                   o_busy,
    output logic [COUNT_WIDTH-1:0] o_evict_count
);

    // The settle counter only has to hold SETTLE_CYCLES-1.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REPLACE = 2'd1,
        SETTLE  = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        settle_cnt_reg, settle_cnt_next;
    logic                    out_valid_reg;
    logic [DATA_WIDTH-1:0]   out_data_reg;
    logic [DATA_WIDTH-1:0]   replace_data_reg;
    logic [COUNT_WIDTH-1:0]  evict_count_reg;

    logic in_fire;
    logic out_fire;

    // A key may only be taken when the single output slot is free or is
    // being drained on this same edge; otherwise the eviction would be lost.
    assign o_in_ready = (state_reg == IDLE) && (!out_valid_reg || i_out_ready);
    assign in_fire    = i_in_valid && o_in_ready;
    assign out_fire   = out_valid_reg && i_out_ready;

    // Decoded straight from the state register so the pulse vanishes the
    // moment reset is asserted and can never be stretched.
    assign o_replace      = (state_reg == REPLACE);
    assign o_busy         = (state_reg != IDLE);
    assign o_out_valid    = out_valid_reg;
    assign o_out_data     = out_data_reg;
    assign o_replace_data = replace_data_reg;
    assign o_evict_count  = evict_count_reg;

    // Next-state logic
    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_fire) begin
                    state_next = REPLACE;
                end
            end
            REPLACE: begin
                state_next      = SETTLE;
                settle_cnt_next = SETTLE_LOAD;
            end
            SETTLE: begin
                if (settle_cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    settle_cnt_next = settle_cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= IDLE;
            settle_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
        end
    end

    // Data path: key capture, output buffer and eviction counter.
    // The tree top is sampled only on the accepting edge, when the tree is
    // known to be settled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            replace_data_reg <= '0;
            out_valid_reg    <= 1'b0;
            out_data_reg     <= '0;
            evict_count_reg  <= '0;
        end else begin
            if (in_fire) begin
                replace_data_reg <= i_in_data;
                out_data_reg     <= i_top_data;
            end

            // A reload on the same edge as a drain keeps the slot full.
            if (in_fire) begin
                out_valid_reg <= 1'b1;
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end

            if (out_fire) begin
                evict_count_reg <= evict_count_reg + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_register_tree_feeder.sv
module tb_register_tree_feeder;

    localparam int DW = 32;
    localparam int SC = 3;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          i_in_valid = 1'b0;
    logic [DW-1:0] i_in_data = '0;
    logic          i_out_ready = 1'b0;
    logic [DW-1:0] i_top_data;
    logic          o_in_ready;
    logic          o_out_valid;
    logic [DW-1:0] o_out_data;
    logic          o_replace;
    logic [DW-1:0] o_replace_data;
    logic          o_busy;
    logic [CW-1:0] o_evict_count;

    register_tree_feeder #(
        .DATA_WIDTH   (DW),
        .SETTLE_CYCLES(SC),
        .COUNT_WIDTH  (CW)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .i_in_valid    (i_in_valid),
        .o_in_ready    (o_in_ready),
        .i_in_data     (i_in_data),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_out_data    (o_out_data),
        .o_replace     (o_replace),
        .o_replace_data(o_replace_data),
        .i_top_data    (i_top_data),
        .o_busy        (o_busy),
        .o_evict_count (o_evict_count)
    );

    always #5 CLK = ~CLK;

    int vec_count = 0;
    int err_count = 0;
    int cyc = 0;
    int tree_q[$];
    int model_q[$];
    int exp_q[$];
    int out_n = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic int max_idx(input int q[$]);
        int m = 0;
        for (int i = 1; i < q.size(); i++) begin
            if (q[i] > q[m]) m = i;
        end
        return m;
    endfunction

    // Behavioural stand-in for the attached tree (QUEUE_SIZE=8, top 80).
    // Reloaded on every reset so each scenario starts from the same contents.
    always @(posedge CLK or posedge RST) begin : tree_model
        int idx;
        if (RST) begin
            tree_q = '{80, 70, 60, 50, 40, 30, 20, 10};
            i_top_data = 32'd80;
        end else begin
            cyc++;
            if (o_replace) begin
                idx = max_idx(tree_q);
                tree_q.delete(idx);
                tree_q.push_back(int'(o_replace_data));
                idx = max_idx(tree_q);
                i_top_data = DW'(tree_q[idx]);
            end
        end
    end

    // Scoreboard: inputs only change at posedge+1, so the values seen at the
    // falling edge decide what handshakes happen on the next rising edge.
    always @(negedge CLK or posedge RST) begin : scoreboard
        int idx;
        int e;
        if (RST) begin
            model_q = '{80, 70, 60, 50, 40, 30, 20, 10};
            exp_q.delete();
        end else begin
            if (o_out_valid && i_out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", 64'(o_out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    out_n++;
                    $display("out #%0d: evicted %0d expected %0d count %0d", out_n, o_out_data, e, o_evict_count);
                    check_val("evict", 64'(o_out_data), 64'(e));
                end
            end
            if (i_in_valid && o_in_ready) begin
                idx = max_idx(model_q);
                exp_q.push_back(model_q[idx]);
                $display("in: key %0d accepted, expect eviction %0d", i_in_data, model_q[idx]);
                model_q.delete(idx);
                model_q.push_back(int'(i_in_data));
            end
        end
    end

    task automatic apply_reset();
        @(posedge CLK);
        #3 RST = 1'b1;
        @(posedge CLK);
        #3 RST = 1'b0;
    endtask

    // Presents a key and returns just after the accepting edge with valid
    // still high; hs is the cycle number of that edge (-1 on timeout).
    task automatic send_key(input int k, output int hs);
        int  n = 0;
        bit  fire = 1'b0;
        i_in_valid = 1'b1;
        i_in_data  = DW'(k);
        hs = -1;
        while (!fire && n < 60) begin
            @(negedge CLK);
            fire = o_in_ready;
            @(posedge CLK);
            #1;
            n++;
        end
        if (fire) hs = cyc;
        else check_val("handshake_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int h0, h1, h2;
        int busy_n, rep_n, k, n;

        // ---- Reset asserted mid-cycle from power-up ----
        #3 RST = 1'b1;
        #1;
        check_val("rst_replace", 64'(o_replace), 64'd0);
        check_val("rst_replace_data", 64'(o_replace_data), 64'd0);
        check_val("rst_out_valid", 64'(o_out_valid), 64'd0);
        check_val("rst_out_data", 64'(o_out_data), 64'd0);
        check_val("rst_count", 64'(o_evict_count), 64'd0);
        check_val("rst_busy", 64'(o_busy), 64'd0);
        check_val("rst_in_ready", 64'(o_in_ready), 64'd1);
        @(posedge CLK);
        #3 RST = 1'b0;
        #1 check_val("post_rst_in_ready", 64'(o_in_ready), 64'd1);

        // ---- Single replace ----
        apply_reset();
        i_out_ready = 1'b1;
        send_key(200, h0);
        i_in_valid = 1'b0;
        check_val("single_out_valid", 64'(o_out_valid), 64'd1);
        check_val("single_out_data", 64'(o_out_data), 64'd80);
        check_val("single_replace", 64'(o_replace), 64'd1);
        check_val("single_replace_data", 64'(o_replace_data), 64'd200);
        check_val("single_in_ready_busy", 64'(o_in_ready), 64'd0);
        busy_n = 1;
        rep_n  = 1;
        n = 0;
        while (n < 20) begin
            @(posedge CLK);
            #1;
            n++;
            if (!o_busy) break;
            busy_n++;
            if (o_replace) rep_n++;
        end
        check_val("single_busy_cycles", 64'(busy_n), 64'(1 + SC));
        check_val("single_replace_cycles", 64'(rep_n), 64'd1);
        check_val("single_tree_top", 64'(i_top_data), 64'd200);
        check_val("single_replace_hold", 64'(o_replace_data), 64'd200);
        check_val("single_count", 64'(o_evict_count), 64'd1);

        // ---- Back-to-back with valid held ----
        apply_reset();
        i_out_ready = 1'b1;
        send_key(5, h0);
        send_key(250, h1);
        send_key(7, h2);
        i_in_valid = 1'b0;
        check_val("b2b_gap1", 64'(h1 - h0), 64'(SC + 2));
        check_val("b2b_gap2", 64'(h2 - h1), 64'(SC + 2));
        repeat (2) @(posedge CLK);
        #1;
        check_val("b2b_count", 64'(o_evict_count), 64'd3);
        check_val("b2b_drained", 64'(exp_q.size()), 64'd0);

        // ---- Backpressure ----
        apply_reset();
        i_out_ready = 1'b0;
        send_key(5, h0);
        i_in_data = 32'd250;
        repeat (8) @(posedge CLK);
        #1;
        check_val("bp_in_ready", 64'(o_in_ready), 64'd0);
        check_val("bp_out_hold", 64'(o_out_data), 64'd80);
        check_val("bp_count0", 64'(o_evict_count), 64'd0);
        i_out_ready = 1'b1;
        send_key(250, h1);
        i_in_valid = 1'b0;
        check_val("bp_reload_valid", 64'(o_out_valid), 64'd1);
        check_val("bp_reload_data", 64'(o_out_data), 64'd70);
        check_val("bp_count1", 64'(o_evict_count), 64'd1);

        // ---- Reset during SETTLE with output pending ----
        i_out_ready = 1'b0;
        @(posedge CLK);
        #3;
        check_val("mid_in_settle", 64'(o_busy), 64'd1);
        RST = 1'b1;
        #1;
        check_val("mid_out_valid", 64'(o_out_valid), 64'd0);
        check_val("mid_count", 64'(o_evict_count), 64'd0);
        check_val("mid_replace", 64'(o_replace), 64'd0);
        check_val("mid_busy", 64'(o_busy), 64'd0);
        @(posedge CLK);
        #3 RST = 1'b0;

        // ---- End-to-end against the software queue model ----
        apply_reset();
        i_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            k = int'($urandom_range(256, 1));
            send_key(k, h0);
            i_in_valid = 1'b0;
            repeat ($urandom_range(2, 0)) @(posedge CLK);
            #1;
        end
        n = 0;
        while ((o_busy || o_out_valid) && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check_val("e2e_idle", 64'(o_busy || o_out_valid), 64'd0);
        check_val("e2e_count", 64'(o_evict_count), 64'd8);
        check_val("e2e_drained", 64'(exp_q.size()), 64'd0);
        check_val("e2e_tree_top", 64'(i_top_data), 64'(model_q[max_idx(model_q)]));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

    // Global safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
